// File: rtl/imem_loader.sv
// imem_loader: byte-stream front end for the instruction memory write port.
// Parses a 16-bit little-endian word-count header, assembles little-endian
// 32-bit words, writes them to consecutive word addresses from 0 and holds
// the core in reset until the whole program has landed.
module imem_loader #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       instr_in,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    // One extra bit so a header of 0xFFFF compares correctly against DEPTH.
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t              state_reg;
    logic [15:0]         count_reg;
    logic [15:0]         word_idx_reg;
    logic [1:0]          byte_idx_reg;
    logic [23:0]         word_reg;      // lanes 0..2; lane 3 goes straight to instr_in
    logic                byte_ready_reg;
    logic                write_en_reg;
    logic [ADDR_W-1:0]   address_reg;
    logic [31:0]         instr_in_reg;
    logic                cpu_hold_reg;
    logic                done_reg;
    logic                error_reg;
    logic [31:0]         checksum_reg;

    // Header value as it will be once the high byte in flight is taken.
    logic [15:0]         full_count;
    logic [15:0]         word_idx_next;

    assign full_count    = {byte_data, count_reg[7:0]};
    assign word_idx_next = word_idx_reg + 16'd1;

    // Loader FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= HDR_LO;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            byte_idx_reg   <= '0;
            word_reg       <= '0;
            byte_ready_reg <= 1'b1;
            write_en_reg   <= 1'b0;
            address_reg    <= '0;
            instr_in_reg   <= '0;
            cpu_hold_reg   <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            checksum_reg   <= '0;
        end else begin
            write_en_reg <= 1'b0;
            case (state_reg)
                HDR_LO: begin
                    if (byte_valid) begin
                        count_reg[7:0] <= byte_data;
                        state_reg      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (byte_valid) begin
                        count_reg[15:8] <= byte_data;
                        if (full_count == 16'd0) begin
                            state_reg      <= DONE;
                            byte_ready_reg <= 1'b0;
                            cpu_hold_reg   <= 1'b0;
                            done_reg       <= 1'b1;
                        end else if ({1'b0, full_count} > DEPTH_L) begin
                            state_reg      <= ERROR;
                            byte_ready_reg <= 1'b0;
                            error_reg      <= 1'b1;
                        end else begin
                            state_reg    <= DATA;
                            byte_idx_reg <= '0;
                            word_idx_reg <= '0;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        case (byte_idx_reg)
                            2'd0: word_reg[7:0]   <= byte_data;
                            2'd1: word_reg[15:8]  <= byte_data;
                            2'd2: word_reg[23:16] <= byte_data;
                            default: begin
                                state_reg      <= WRITE;
                                byte_ready_reg <= 1'b0;
                                write_en_reg   <= 1'b1;
                                address_reg    <= ADDR_W'(word_idx_reg);
                                instr_in_reg   <= {byte_data, word_reg};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    checksum_reg <= checksum_reg ^ instr_in_reg;
                    word_idx_reg <= word_idx_next;
                    if (word_idx_next == count_reg) begin
                        state_reg    <= DONE;
                        cpu_hold_reg <= 1'b0;
                        done_reg     <= 1'b1;
                    end else begin
                        state_reg      <= DATA;
                        byte_ready_reg <= 1'b1;
                    end
                end
                DONE, ERROR: begin
                    // Re-arm: address and instr_in keep their last written values.
                    if (start) begin
                        state_reg      <= HDR_LO;
                        count_reg      <= '0;
                        word_idx_reg   <= '0;
                        byte_idx_reg   <= '0;
                        checksum_reg   <= '0;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                        cpu_hold_reg   <= 1'b1;
                        byte_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg      <= HDR_LO;
                    byte_ready_reg <= 1'b1;
                    cpu_hold_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_reg;
    assign write_en   = write_en_reg;
    assign address    = address_reg;
    assign instr_in   = instr_in_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign checksum   = checksum_reg;

endmodule
